// File: rtl/dcache_miss_controller.sv
// Data cache miss sequencer: write-through single-word stores, LineWords-word refills on load misses.
// Stalls the core until the pending request retires in DONE; load hits pass with no added cycles.
module dcache_miss_controller #(
  parameter int WordSize  = 32,
  parameter int AddrSize  = 32,
  parameter int LineWords = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_rw,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [WordSize-1:0] req_wdata,
  input  logic                hit,
  output logic                stall,
  output logic                cache_wr,
  output logic                fill_en,
  output logic [AddrSize-1:0] fill_addr,
  output logic [WordSize-1:0] fill_data,
  output logic                mem_request,
  output logic                mem_write_enable,
  output logic [AddrSize-1:0] mem_addr,
  output logic [WordSize-1:0] mem_wdata,
  input  logic                mem_busy,
  input  logic                mem_rvalid,
  input  logic [WordSize-1:0] mem_rdata
);

  localparam int BB = $clog2(WordSize / 8);
  localparam int CW = $clog2(LineWords);
  localparam logic [AddrSize-1:0] LINE_MASK = ~((AddrSize'(1) << (BB + CW)) - AddrSize'(1));
  localparam logic [CW-1:0] CNT_LAST = CW'(LineWords - 1);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AddrSize-1:0] addr_q, addr_d;
  logic [WordSize-1:0] wdata_q, wdata_d;
  logic                hit_q, hit_d;
  logic [AddrSize-1:0] word_addr;

  // Sum wraps modulo 2^AddrSize, so a line at the top of memory needs no special case.
  assign word_addr = addr_q + (AddrSize'(cnt_q) << BB);

  assign stall = req_valid & ~(((state_q == IDLE) & ~req_rw & hit) | (state_q == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    hit_d            = hit_q;
    cache_wr         = 1'b0;
    fill_en          = 1'b0;
    fill_addr        = '0;
    fill_data        = '0;
    mem_request      = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_rw) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          hit_d   = hit;
          state_d = WR;
        end else if (req_valid && !hit) begin
          // hit_q cleared so DONE never issues a cache write for a refill.
          addr_d  = req_addr & LINE_MASK;
          cnt_d   = '0;
          hit_d   = 1'b0;
          state_d = RD_REQ;
        end
      end
      WR: begin
        mem_request      = 1'b1;
        mem_write_enable = 1'b1;
        mem_addr         = addr_q;
        mem_wdata        = wdata_q;
        if (!mem_busy) state_d = DONE;
      end
      RD_REQ: begin
        mem_request = 1'b1;
        mem_addr    = word_addr;
        if (!mem_busy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          fill_en   = 1'b1;
          fill_addr = word_addr;
          fill_data = mem_rdata;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        cache_wr = hit_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/dcache_miss_controller.md
# dcache_miss_controller

Sequencing FSM between the core's load/store port and main memory for the data cache. It turns write requests into single-word write-through memory writes and read misses into line refills of `LineWords` sequential word reads. It drives the cache fill port and stalls the core until each request retires. It sits alongside the data cache manager glue and uses its memory handshake signals (`mem_request`, `mem_write_enable`, `mem_busy`).

## Interface
- `WordSize`, 32, data word width in bits (multiple of 8)
- `AddrSize`, 32, byte address width
- `LineWords`, 4, words per cache line (power of 2, ≥2)

- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  core has a load/store pending; held with its fields until `stall` is low
- `req_rw`  in  1  1 = store, 0 = load
- `req_addr`  in  AddrSize  byte address, word aligned
- `req_wdata`  in  WordSize  store data
- `hit`  in  1  tag match for `req_addr`, combinational from the tag array
- `stall`  out  1  core must hold the request
- `cache_wr`  out  1  one-cycle pulse: write `req_wdata` into the cache at `req_addr` (store hit update)
- `fill_en`  out  1  one-cycle pulse: write `fill_data` at `fill_addr`
- `fill_addr`  out  AddrSize  word address being refilled
- `fill_data`  out  WordSize  refill word
- `mem_request`  out  1  memory request valid
- `mem_write_enable`  out  1  1 = write, 0 = read
- `mem_addr`  out  AddrSize  memory byte address
- `mem_wdata`  out  WordSize  memory write data
- `mem_busy`  in  1  memory cannot accept; a request is accepted in any cycle with `mem_request & ~mem_busy`
- `mem_rvalid`  in  1  read data valid, one pulse per accepted read, in order
- `mem_rdata`  in  WordSize  read data

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, DONE. Word counter `cnt`, log2(LineWords) bits. Latched registers: `addr_q`, `wdata_q`, `hit_q`.
- IDLE:
  - `req_valid & req_rw` → latch addr/wdata/hit; go to WR.
  - `req_valid & ~req_rw & ~hit` → latch the line base (`req_addr` with the low log2(WordSize/8)+log2(LineWords) bits zeroed) into `addr_q`; `cnt`=0; go to RD_REQ.
  - A load hit or no request → stay in IDLE.
- WR: `mem_request`=1, `mem_write_enable`=1, `mem_addr`=`addr_q`, `mem_wdata`=`wdata_q`. On acceptance → DONE.
- RD_REQ: `mem_request`=1, `mem_write_enable`=0, `mem_addr`=`addr_q` + `cnt`·(WordSize/8). On acceptance → RD_WAIT.
- RD_WAIT: `mem_request`=0. On `mem_rvalid`: `fill_en`=1, `fill_addr`=current word address, `fill_data`=`mem_rdata`.
  - If `cnt`==LineWords−1 → DONE.
  - Otherwise `cnt`+1 → RD_REQ.
- DONE: single cycle. `cache_wr` = store & `hit_q`. Then → IDLE. A refilled load hits the array this cycle.
- `stall` = `req_valid & ~((IDLE & ~req_rw & hit) | DONE)`. It is combinational.
- Writes are no-write-allocate: a store miss updates memory only.
- Address arithmetic wraps modulo 2^AddrSize. `cnt` never exceeds LineWords−1.
- `mem_rvalid` outside RD_WAIT is ignored.
- `req_*` changes while stalled are illegal and are not checked.

## Timing
- Reset state: IDLE, `cnt`=0, all latched registers 0. `mem_request`, `fill_en` and `cache_wr` are 0. `mem_addr`, `mem_wdata`, `fill_addr` and `fill_data` are 0. `stall` follows `req_valid`.
- Reset asserted mid-operation: immediately back to IDLE. The partial refill is abandoned and the line is left for the tag logic to keep invalid. Outstanding `mem_rvalid` pulses after reset are ignored.
- Load hit: zero added cycles, `stall`=0 in the request cycle.
- Store with memory idle: `stall` is high in IDLE and WR, low in DONE. Retires 2 cycles after `req_valid`, plus one cycle per `mem_busy`-high cycle in WR.
- Read miss with zero busy cycles and rvalid one cycle after acceptance: 1 (IDLE) + LineWords·2 + 1 (DONE) = 10 cycles for LineWords=4.
- `mem_busy` high holds `mem_request` and `mem_addr` stable until acceptance.
- `mem_rvalid` in the same cycle as entry into RD_WAIT cannot occur, since acceptance is registered.

## Test plan
- Reset then load hit: `req_valid`=1, `req_rw`=0, `hit`=1 → `stall`=0 the same cycle; `mem_request` stays 0.
- Store 0xDEADBEEF to 0x100 with hit, `mem_busy` high 3 cycles → `mem_request`/`mem_write_enable`=1 with `mem_addr`=0x100 held 4 cycles. Next cycle DONE: `cache_wr`=1 and `stall`=0.
- Load miss at 0x1238 (LineWords=4) → reads at 0x1230, 0x1234, 0x1238, 0x123C in order. `fill_en` pulses carry the returned data at matching `fill_addr`. `stall` drops in DONE, 10 cycles after issue with no busy.
- Store miss to 0x40 → memory write issued; `cache_wr` stays 0 in DONE.
- `rst` asserted during RD_WAIT of the 2nd word → IDLE next edge with all outputs 0. A later `mem_rvalid` causes no `fill_en`.
- Load miss at 0xFFFFFFFC → line base 0xFFFFFFF0; last read at 0xFFFFFFFC with no wrap error.
